fifo_drain: RTL

- Read-side controller for the team's synchronous FIFO.
- Watches the FIFO's empty flag, issues pops, and captures pop data in the same cycle as the pop, because FIFO pop data is valid combinationally in the pop cycle.
- Re-presents the data on a registered valid/ready stream with a 2-entry skid buffer.
- Frames that stream into fixed-length bursts with a last flag, and counts completed bursts.

---
 rtl/fifo_drain.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_drain.sv
// Read-side controller for the synchronous FIFO: pops into a 2-entry skid buffer,
// re-presents beats on a registered valid/ready stream, frames them into bursts.
module fifo_drain #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_pop_data_i,
  output logic              fifo_pop_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  burst_cnt_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  // Stream handshake: a beat moves when out_valid_o && out_ready_i on a rising
  // edge; while out_valid_o is high, out_data_o/out_last_o hold until that edge.

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              pop;
  logic              xfer;

  always_comb begin
    // Pop decision never looks at out_ready_i: no ready-to-pop combinational path.
    pop     = !reset && enable_i && !fifo_empty_i && (count_q != 2'd2);
    xfer    = valid_q && out_ready_i;
    count_d = count_q + {1'b0, pop} - {1'b0, xfer};
    head_d  = head_q;
    tail_d  = tail_q;
    beat_d  = beat_q;
    burst_d = burst_q;

    if (xfer) begin
      head_d = tail_q;
      beat_d = last_q ? '0 : beat_q + BEAT_W'(1);
      if (last_q) burst_d = burst_q + CNT_W'(1);
    end

    // Pop data lands in the first slot that is free after this edge's transfer.
    if (pop) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && xfer)) head_d = fifo_pop_data_i;
      else tail_d = fifo_pop_data_i;
    end

    valid_d = (count_d != 2'd0);
    last_d  = valid_d && (beat_d == BEAT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign fifo_pop_o  = pop;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign out_last_o  = last_q;
  assign busy_o      = valid_q;
  assign burst_cnt_o = burst_q;

endmodule
